// File: rtl/navigate_prof.sv
// Maze-navigation move sequencer: heading changes with timeout, forward moves with
// ramped speed, stop at the Nth qualifying side opening, and abort handling.
module navigate_prof #(
    parameter int unsigned SPD_W      = 11,
    parameter int unsigned MAX_SPD    = 672,
    parameter int unsigned MIN_SPD    = 208,
    parameter int unsigned INC        = 24,
    parameter int unsigned DECN_SHIFT = 1,
    parameter int unsigned DECF_SHIFT = 3,
    parameter int unsigned CNT_W      = 3,
    parameter int unsigned TMO_W      = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             strt_hdng,
    input  logic             strt_mv,
    input  logic             abort,
    input  logic             stp_lft,
    input  logic             stp_rght,
    input  logic [CNT_W-1:0] opn_cnt,
    input  logic             hdng_rdy,
    input  logic             at_hdng,
    input  logic             lft_opn,
    input  logic             rght_opn,
    input  logic             frwrd_opn,
    output logic             mv_cmplt,
    output logic             mv_err,
    output logic             moving,
    output logic             en_fusion,
    output logic [SPD_W-1:0] frwrd_spd,
    output logic [2:0]       state_o
);

    localparam int unsigned EW = SPD_W + 1;
    localparam logic [EW-1:0]    MAX_E   = EW'(MAX_SPD);
    localparam logic [EW-1:0]    INC_E   = EW'(INC);
    localparam logic [EW-1:0]    STEP_N  = EW'(INC << DECN_SHIFT);
    localparam logic [EW-1:0]    STEP_F  = EW'(INC << DECF_SHIFT);
    localparam logic [SPD_W-1:0] HALF_SP = SPD_W'(MAX_SPD >> 1);
    // Last count before the timeout value is reached; exit fires as the counter gets there.
    localparam logic [TMO_W-1:0] TMO_PRE = {{(TMO_W-1){1'b1}}, 1'b0};

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HEAD = 3'd1,
        ACCL = 3'd2,
        DECN = 3'd3,
        DECF = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [SPD_W-1:0] spd_q, spd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             err_q, err_d;
    logic             mv_cmplt_q, mv_cmplt_d;
    logic             mv_err_q, mv_err_d;
    logic             moving_q, moving_d;
    logic             en_fusion_q, en_fusion_d;
    logic             lft_opn_q, rght_opn_q, at_hdng_q;

    logic             lft_rise, rght_rise, at_rise, qual_rise;
    logic [EW-1:0]    spd_e, spd_up, step;

    assign lft_rise  = lft_opn & ~lft_opn_q;
    assign rght_rise = rght_opn & ~rght_opn_q;
    assign at_rise   = at_hdng & ~at_hdng_q;
    assign qual_rise = (lft_rise & stp_lft) | (rght_rise & stp_rght);

    assign spd_e  = {1'b0, spd_q};
    assign spd_up = spd_e + INC_E;
    assign step   = (state_q == DECF) ? STEP_F : STEP_N;

    // Next-state, speed ramp, opening count and heading timeout.
    always_comb begin
        state_d = state_q;
        spd_d   = spd_q;
        cnt_d   = cnt_q;
        tmo_d   = tmo_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (strt_mv) begin
                    state_d = ACCL;
                    spd_d   = SPD_W'(MIN_SPD);
                    cnt_d   = (opn_cnt == '0) ? CNT_W'(1) : opn_cnt;
                    err_d   = 1'b0;
                end else if (strt_hdng) begin
                    state_d = HEAD;
                    tmo_d   = '0;
                    err_d   = 1'b0;
                end
            end
            HEAD: begin
                tmo_d = tmo_q + TMO_W'(1);
                if (abort || tmo_q == TMO_PRE) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end else if (at_rise) begin
                    state_d = IDLE;
                end
            end
            ACCL: begin
                if (hdng_rdy) spd_d = (spd_up > MAX_E) ? SPD_W'(MAX_SPD) : spd_up[SPD_W-1:0];
                if (abort) begin
                    state_d = DECF;
                    err_d   = 1'b1;
                end else if (!frwrd_opn) begin
                    state_d = DECF;
                end else if (qual_rise) begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) state_d = DECN;
                end
            end
            DECN, DECF: begin
                if (hdng_rdy) spd_d = (spd_e > step) ? SPD_W'(spd_e - step) : '0;
                if (abort && state_q == DECN) err_d = 1'b1;
                if (spd_q == '0) state_d = IDLE;
                else if (state_q == DECN && (abort || !frwrd_opn)) state_d = DECF;
            end
            default: state_d = IDLE;
        endcase
        mv_cmplt_d  = (state_q != IDLE) && (state_d == IDLE);
        mv_err_d    = mv_cmplt_d && err_d;
        moving_d    = (state_d != IDLE);
        en_fusion_d = (spd_d > HALF_SP);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            spd_q       <= '0;
            cnt_q       <= '0;
            tmo_q       <= '0;
            err_q       <= 1'b0;
            mv_cmplt_q  <= 1'b0;
            mv_err_q    <= 1'b0;
            moving_q    <= 1'b0;
            en_fusion_q <= 1'b0;
            lft_opn_q   <= 1'b1;
            rght_opn_q  <= 1'b1;
            at_hdng_q   <= 1'b1;
        end else begin
            state_q     <= state_d;
            spd_q       <= spd_d;
            cnt_q       <= cnt_d;
            tmo_q       <= tmo_d;
            err_q       <= err_d;
            mv_cmplt_q  <= mv_cmplt_d;
            mv_err_q    <= mv_err_d;
            moving_q    <= moving_d;
            en_fusion_q <= en_fusion_d;
            lft_opn_q   <= lft_opn;
            rght_opn_q  <= rght_opn;
            at_hdng_q   <= at_hdng;
        end
    end

    assign mv_cmplt  = mv_cmplt_q;
    assign mv_err    = mv_err_q;
    assign moving    = moving_q;
    assign en_fusion = en_fusion_q;
    assign frwrd_spd = spd_q;
    assign state_o   = 3'(state_q);

endmodule

// File: tb/tb_navigate_prof.sv
// Self-checking bench for navigate_prof: table-driven speed profiles plus hand-written
// sequences for opening counts, heading timeout, abort and mid-move reset.
module tb_navigate_prof;

    logic        clk = 1'b0;
    logic        rst, strt_hdng, strt_mv, abort, stp_lft, stp_rght;
    logic [2:0]  opn_cnt;
    logic        hdng_rdy, at_hdng, lft_opn, rght_opn, frwrd_opn;
    logic        mv_cmplt, mv_err, moving, en_fusion;
    logic [10:0] frwrd_spd;
    logic [2:0]  state_o;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic rdy;
        logic opn;
        int   spd;
        logic fus;
        int   st;
    } vec_t;

    vec_t ramp_tbl[26];
    vec_t decf_tbl[4];
    vec_t exp_q[$];

    navigate_prof #(.TMO_W(4)) dut (
        .clk(clk), .rst(rst), .strt_hdng(strt_hdng), .strt_mv(strt_mv), .abort(abort),
        .stp_lft(stp_lft), .stp_rght(stp_rght), .opn_cnt(opn_cnt), .hdng_rdy(hdng_rdy),
        .at_hdng(at_hdng), .lft_opn(lft_opn), .rght_opn(rght_opn), .frwrd_opn(frwrd_opn),
        .mv_cmplt(mv_cmplt), .mv_err(mv_err), .moving(moving), .en_fusion(en_fusion),
        .frwrd_spd(frwrd_spd), .state_o(state_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: act=timeout req=finish");
        $fatal(1);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: act=%0d req=%0d", name, act, req);
        end
    endtask

    // Drive one vector, queue its expectation, compare once the edge has produced output.
    task automatic run_vec(input vec_t v);
        vec_t e;
        hdng_rdy  = v.rdy;
        frwrd_opn = v.opn;
        exp_q.push_back(v);
        cyc();
        hdng_rdy = 1'b0;
        e = exp_q.pop_front();
        chk("spd", int'(frwrd_spd), e.spd);
        chk("en_fusion", int'(en_fusion), int'(e.fus));
        chk("state", int'(state_o), e.st);
    endtask

    // Pulse hdng_rdy until mv_cmplt appears; checks the completion pulse and error flag.
    task automatic drain(input int req_err);
        bit seen = 0;
        for (int i = 0; i < 80; i++) begin
            hdng_rdy = 1'b1;
            cyc();
            if (mv_cmplt) begin
                seen = 1;
                break;
            end
        end
        hdng_rdy = 1'b0;
        chk("cmplt_seen", int'(seen), 1);
        chk("mv_err", int'(mv_err), req_err);
        chk("spd_done", int'(frwrd_spd), 0);
        chk("state_done", int'(state_o), 0);
        cyc();
        chk("cmplt_once", int'(mv_cmplt), 0);
    endtask

    task automatic start_mv(input logic [2:0] n);
        opn_cnt = n;
        strt_mv = 1'b1;
        cyc();
        strt_mv = 1'b0;
        chk("mv_start_state", int'(state_o), 2);
        chk("mv_start_spd", int'(frwrd_spd), 208);
    endtask

    initial begin
        int m;
        int n;
        m = 208;
        for (int i = 0; i < 26; i++) begin
            ramp_tbl[i].rdy = (i != 5);
            if (ramp_tbl[i].rdy) m = (m + 24 > 672) ? 672 : m + 24;
            ramp_tbl[i].opn = 1'b1;
            ramp_tbl[i].spd = m;
            ramp_tbl[i].fus = (m > 336);
            ramp_tbl[i].st  = 2;
        end
        decf_tbl[0] = '{1'b1, 1'b0, 480, 1'b1, 4};
        decf_tbl[1] = '{1'b1, 1'b0, 288, 1'b0, 4};
        decf_tbl[2] = '{1'b1, 1'b0, 96,  1'b0, 4};
        decf_tbl[3] = '{1'b1, 1'b0, 0,   1'b0, 4};

        rst = 1'b1; strt_hdng = 0; strt_mv = 0; abort = 0; stp_lft = 0; stp_rght = 0;
        opn_cnt = 3'd0; hdng_rdy = 0; at_hdng = 0; lft_opn = 0; rght_opn = 0; frwrd_opn = 1;
        repeat (2) cyc();
        rst = 1'b0;
        chk("rst_state", int'(state_o), 0);
        chk("rst_spd", int'(frwrd_spd), 0);
        chk("rst_moving", int'(moving), 0);
        chk("rst_cmplt", int'(mv_cmplt), 0);

        // Ramp to ceiling, then fast decel on blocked path.
        start_mv(3'd0);
        chk("mv_moving", int'(moving), 1);
        foreach (ramp_tbl[i]) run_vec(ramp_tbl[i]);
        frwrd_opn = 1'b0;
        cyc();
        chk("decf_entry", int'(state_o), 4);
        chk("decf_hold_spd", int'(frwrd_spd), 672);
        foreach (decf_tbl[i]) run_vec(decf_tbl[i]);
        drain(0);
        frwrd_opn = 1'b1;

        // Second qualifying left opening stops; normal decel of 48 per step.
        stp_lft = 1'b1;
        start_mv(3'd2);
        m = 208;
        for (int i = 0; i < 20; i++) begin
            m = (m + 24 > 672) ? 672 : m + 24;
            run_vec('{1'b1, 1'b1, m, (m > 336), 2});
        end
        lft_opn = 1'b1; cyc();
        chk("first_lft_rise", int'(state_o), 2);
        lft_opn = 1'b0; cyc();
        lft_opn = 1'b1; cyc();
        chk("second_lft_rise", int'(state_o), 3);
        for (int i = 1; i <= 14; i++) begin
            m = 672 - 48 * i;
            run_vec('{1'b1, 1'b1, m, (m > 336), 3});
        end
        drain(0);
        lft_opn = 1'b0; stp_lft = 1'b0;

        // Simultaneous left+right rise counts once.
        stp_lft = 1'b1; stp_rght = 1'b1;
        start_mv(3'd2);
        lft_opn = 1'b1; rght_opn = 1'b1; cyc();
        chk("dual_rise_once", int'(state_o), 2);
        lft_opn = 1'b0; rght_opn = 1'b0; cyc();
        lft_opn = 1'b1; cyc();
        chk("dual_then_single", int'(state_o), 3);
        drain(0);
        lft_opn = 1'b0; cyc();

        // opn_cnt of zero stops at the first opening.
        start_mv(3'd0);
        rght_opn = 1'b1; cyc();
        chk("cnt0_first_rise", int'(state_o), 3);
        drain(0);
        rght_opn = 1'b0; stp_lft = 1'b0; stp_rght = 1'b0;

        // Heading timeout after 15 cycles in HEAD.
        strt_hdng = 1'b1; cyc(); strt_hdng = 1'b0;
        n = 0;
        while (state_o == 3'd1 && n < 40) begin
            n++;
            cyc();
        end
        chk("head_cycles", n, 15);
        chk("tmo_cmplt", int'(mv_cmplt), 1);
        chk("tmo_err", int'(mv_err), 1);
        chk("tmo_spd", int'(frwrd_spd), 0);
        cyc();
        chk("tmo_cmplt_once", int'(mv_cmplt), 0);

        // Heading reached early.
        strt_hdng = 1'b1; cyc(); strt_hdng = 1'b0;
        chk("head_state", int'(state_o), 1);
        repeat (3) cyc();
        at_hdng = 1'b1; cyc();
        chk("hdng_ok_state", int'(state_o), 0);
        chk("hdng_ok_cmplt", int'(mv_cmplt), 1);
        chk("hdng_ok_err", int'(mv_err), 0);
        at_hdng = 1'b0; cyc();

        // Abort in HEAD.
        strt_hdng = 1'b1; cyc(); strt_hdng = 1'b0;
        abort = 1'b1; cyc(); abort = 1'b0;
        chk("head_abort_cmplt", int'(mv_cmplt), 1);
        chk("head_abort_err", int'(mv_err), 1);

        // Abort in ACCL; strt_hdng ignored while moving.
        start_mv(3'd1);
        m = 208;
        for (int i = 0; i < 3; i++) begin
            m = m + 24;
            run_vec('{1'b1, 1'b1, m, (m > 336), 2});
        end
        strt_hdng = 1'b1; cyc(); strt_hdng = 1'b0;
        chk("strt_hdng_ignored", int'(state_o), 2);
        abort = 1'b1; cyc(); abort = 1'b0;
        chk("abort_decf", int'(state_o), 4);
        drain(1);

        // Reset mid-ACCL: back to IDLE with no completion pulse.
        start_mv(3'd1);
        run_vec('{1'b1, 1'b1, 232, 1'b0, 2});
        rst = 1'b1; cyc();
        chk("rst_mid_state", int'(state_o), 0);
        chk("rst_mid_spd", int'(frwrd_spd), 0);
        chk("rst_mid_cmplt", int'(mv_cmplt), 0);
        rst = 1'b0; cyc();
        chk("rst_mid_cmplt_after", int'(mv_cmplt), 0);
        chk("rst_mid_moving", int'(moving), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
